// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared types and constants for the data-memory arbiter.
//   owner_e : which port owns the read data returning next cycle.
//   MEM_RD / MEM_WR : encoding of the rw direction bit.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_EXT  = 2'd2
   } owner_e;

   localparam logic MEM_RD = 1'b0;
   localparam logic MEM_WR = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the CPU port, the EXT loader/debug port and the data-memory port of the arbiter.
//   modport slave  : the arbiter (consumes requests and mem_rdata, drives grants and mem_*).
//   modport master : the environment (pipeline, EXT master and memory).
//   DMEM_ARB_LOCK_EN adds the ext_lock request qualifier.
interface dmem_arbiter_if #(
   parameter int unsigned AW = 16,
   parameter int unsigned DW = 16
);
   // CPU port
   logic          cpu_en;
   logic          cpu_rw;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_stall;
   logic [DW-1:0] cpu_rdata;
   // EXT port
   logic          ext_req;
   logic          ext_rw;
   logic [AW-1:0] ext_addr;
   logic [DW-1:0] ext_wdata;
`ifdef DMEM_ARB_LOCK_EN
   logic          ext_lock;
`endif
   logic          ext_gnt;
   logic          ext_rvalid;
   logic [DW-1:0] ext_rdata;
   // Memory port
   logic          mem_en;
   logic          mem_rw;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  cpu_en, cpu_rw, cpu_addr, cpu_wdata,
      output cpu_stall, cpu_rdata,
      input  ext_req, ext_rw, ext_addr, ext_wdata,
`ifdef DMEM_ARB_LOCK_EN
      input  ext_lock,
`endif
      output ext_gnt, ext_rvalid, ext_rdata,
      output mem_en, mem_rw, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_en, cpu_rw, cpu_addr, cpu_wdata,
      input  cpu_stall, cpu_rdata,
      output ext_req, ext_rw, ext_addr, ext_wdata,
`ifdef DMEM_ARB_LOCK_EN
      output ext_lock,
`endif
      input  ext_gnt, ext_rvalid, ext_rdata,
      input  mem_en, mem_rw, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_arb_wait_ctr.sv
// dmem_arb_wait_ctr
//   Saturating starvation counter: counts conflict cycles an EXT request has lost.
//   clk, reset : clock, synchronous active-high reset
//   inc_i      : EXT lost a conflict this cycle
//   clr_i      : EXT granted or not requesting (has priority over inc_i)
//   hit_o      : count has reached MaxWait-1, next conflict must go to EXT
module dmem_arb_wait_ctr #(
   parameter int unsigned MaxWait = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc_i,
   input  logic clr_i,
   output logic hit_o
);

   localparam int unsigned CntW = (MaxWait > 1) ? $clog2(MaxWait) : 1;

   logic [CntW-1:0] cnt_d, cnt_q;

   assign hit_o = (cnt_q == CntW'(MaxWait - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !hit_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the CPU (DM stage) and an EXT loader/debug
//   master. CPU has priority; after MAX_WAIT-1 lost conflicts the next conflict goes to EXT
//   and the CPU is stalled for that cycle. Read data (1-cycle latency) is routed to its owner.
//   clk, reset : clock, synchronous active-high reset (all outputs forced to 0 while high)
//   bus        : dmem_arbiter_if.slave carrying the CPU, EXT and memory ports
//   Optional feature macro: DMEM_ARB_LOCK_EN (ext_lock keeps EXT ownership after a grant).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AW       = 16,
   parameter int unsigned DW       = 16,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);

   logic   cpu_grant, ext_grant;
   logic   cnt_inc, cnt_clr, cnt_hit;
   owner_e rd_owner_d, rd_owner_q;
`ifdef DMEM_ARB_LOCK_EN
   logic   ext_gnt_d, ext_gnt_q;
   logic   lock_hold;

   // Lock only extends an existing EXT grant; it never preempts the CPU on its own.
   assign lock_hold = bus.ext_lock & bus.ext_req & ext_gnt_q;
   assign ext_gnt_d = ext_grant;
`endif

   dmem_arb_wait_ctr #(
      .MaxWait (MAX_WAIT)
   ) u_wait_ctr (
      .clk   (clk),
      .reset (reset),
      .inc_i (cnt_inc),
      .clr_i (cnt_clr),
      .hit_o (cnt_hit)
   );

   always_comb begin
      cpu_grant = bus.cpu_en & ~(bus.ext_req & cnt_hit);
      ext_grant = bus.ext_req & ~cpu_grant;
      cnt_inc   = bus.cpu_en & bus.ext_req & cpu_grant;
      cnt_clr   = ~bus.ext_req | ext_grant;
`ifdef DMEM_ARB_LOCK_EN
      if (lock_hold) begin
         cpu_grant = 1'b0;
         ext_grant = 1'b1;
         cnt_inc   = 1'b0;
         cnt_clr   = 1'b0;
      end
`endif
      if (reset) begin
         cpu_grant = 1'b0;
         ext_grant = 1'b0;
      end
   end

   // Memory request mux: CPU, EXT or fully idle bus.
   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_rw    = MEM_RD;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (cpu_grant) begin
         bus.mem_en    = 1'b1;
         bus.mem_rw    = bus.cpu_rw;
         bus.mem_addr  = bus.cpu_addr;
         bus.mem_wdata = bus.cpu_wdata;
      end else if (ext_grant) begin
         bus.mem_en    = 1'b1;
         bus.mem_rw    = bus.ext_rw;
         bus.mem_addr  = bus.ext_addr;
         bus.mem_wdata = bus.ext_wdata;
      end
   end

   assign bus.cpu_stall = bus.cpu_en & ~cpu_grant & ~reset;
   assign bus.ext_gnt   = ext_grant;

   always_comb begin
      rd_owner_d = OWN_NONE;
      if (cpu_grant && bus.cpu_rw == MEM_RD) begin
         rd_owner_d = OWN_CPU;
      end else if (ext_grant && bus.ext_rw == MEM_RD) begin
         rd_owner_d = OWN_EXT;
      end
   end

   // Response outputs are also gated by reset so a read granted just before reset is dropped.
   assign bus.ext_rvalid = (rd_owner_q == OWN_EXT) & ~reset;
   assign bus.ext_rdata  = bus.ext_rvalid ? bus.mem_rdata : {DW{1'b0}};
   assign bus.cpu_rdata  = ((rd_owner_q == OWN_CPU) & ~reset) ? bus.mem_rdata : {DW{1'b0}};

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_owner_q <= OWN_NONE;
`ifdef DMEM_ARB_LOCK_EN
         ext_gnt_q  <= 1'b0;
`endif
      end else begin
         rd_owner_q <= rd_owner_d;
`ifdef DMEM_ARB_LOCK_EN
         ext_gnt_q  <= ext_gnt_d;
`endif
      end
   end

   // AW is carried by the interface; keep the parameter referenced for width consistency.
   logic unused_aw;
   assign unused_aw = ^AW;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed-vector scoreboard bench for dmem_arbiter (MAX_WAIT=4). Each vector drives one
//   cycle of inputs and queues the hand-computed outputs; a monitor compares mid-cycle.
module tb_dmem_arbiter;

   typedef struct packed {
      logic        stall;
      logic        gnt;
      logic        rv;
      logic [15:0] crd;
      logic [15:0] erd;
      logic        men;
      logic        mrw;
      logic [15:0] ma;
      logic [15:0] mwd;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   dmem_arbiter_if #(.AW(16), .DW(16)) bus ();

   dmem_arbiter #(
      .AW       (16),
      .DW       (16),
      .MAX_WAIT (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   id_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   vec_id = 0;

   // Monitor: compare whatever the DUT presents against the oldest queued expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_t e, a;
            int   id;
            e = exp_q.pop_front();
            id = id_q.pop_front();
            a = '{stall: bus.cpu_stall, gnt: bus.ext_gnt, rv: bus.ext_rvalid,
                  crd: bus.cpu_rdata, erd: bus.ext_rdata, men: bus.mem_en,
                  mrw: bus.mem_rw, ma: bus.mem_addr, mwd: bus.mem_wdata};
            n_cmp++;
            if (a !== e) begin
               n_err++;
               $display("FAIL vec%0d: got stall=%b gnt=%b rv=%b crd=%h erd=%h men=%b mrw=%b ma=%h mwd=%h, want stall=%b gnt=%b rv=%b crd=%h erd=%h men=%b mrw=%b ma=%h mwd=%h",
                        id, a.stall, a.gnt, a.rv, a.crd, a.erd, a.men, a.mrw, a.ma, a.mwd,
                        e.stall, e.gnt, e.rv, e.crd, e.erd, e.men, e.mrw, e.ma, e.mwd);
            end
         end
      end
   end

   task automatic step(
      input logic rst, input logic ce, input logic crw, input logic [15:0] ca,
      input logic [15:0] cwd, input logic er, input logic erw, input logic [15:0] ea,
      input logic [15:0] ewd, input logic lk, input logic [15:0] mrd,
      input logic st, input logic g, input logic rv, input logic [15:0] crd,
      input logic [15:0] erd, input logic me, input logic mw, input logic [15:0] ma,
      input logic [15:0] mwd);
      exp_t e;
      @(posedge clk);
      #1;
      reset         = rst;
      bus.cpu_en    = ce;
      bus.cpu_rw    = crw;
      bus.cpu_addr  = ca;
      bus.cpu_wdata = cwd;
      bus.ext_req   = er;
      bus.ext_rw    = erw;
      bus.ext_addr  = ea;
      bus.ext_wdata = ewd;
`ifdef DMEM_ARB_LOCK_EN
      bus.ext_lock  = lk;
`endif
      bus.mem_rdata = mrd;
      e = '{stall: st, gnt: g, rv: rv, crd: crd, erd: erd, men: me, mrw: mw, ma: ma, mwd: mwd};
      exp_q.push_back(e);
      id_q.push_back(vec_id);
      vec_id++;
      if (lk === 1'bx) $display("bad lock arg");
   endtask

   initial begin
      bus.cpu_en = 0; bus.cpu_rw = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
      bus.ext_req = 0; bus.ext_rw = 0; bus.ext_addr = 0; bus.ext_wdata = 0;
`ifdef DMEM_ARB_LOCK_EN
      bus.ext_lock = 0;
`endif
      bus.mem_rdata = 0;

      //   rst ce rw ca       cwd      er rw ea       ewd      lk mrd       | st g rv crd      erd      me mw ma       mwd
      // Reset state
      step(1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,16'h0000,  0,0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000);
      // 1: CPU read alone
      step(0, 1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 0,16'h0000,  0,0,0,16'h0000,16'h0000, 1,0,16'h0010,16'h0000);
      step(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,16'hBEEF,  0,0,0,16'hBEEF,16'h0000, 0,0,16'h0000,16'h0000);
      // 2: EXT write alone, then back-to-back EXT write
      step(0, 0,0,16'h0000,16'h0000, 1,1,16'h0020,16'h1234, 0,16'h0000,  0,1,0,16'h0000,16'h0000, 1,1,16'h0020,16'h1234);
      step(0, 0,0,16'h0000,16'h0000, 1,1,16'h0021,16'h5678, 0,16'h0000,  0,1,0,16'h0000,16'h0000, 1,1,16'h0021,16'h5678);
      // 3: sustained conflict, EXT forced every 4th cycle
      step(0, 1,0,16'h0030,16'h0000, 1,0,16'h0040,16'h0000, 0,16'h0000,  0,0,0,16'h0000,16'h0000, 1,0,16'h0030,16'h0000);
      step(0, 1,0,16'h0030,16'h0000, 1,0,16'h0040,16'h0000, 0,16'h1111,  0,0,0,16'h1111,16'h0000, 1,0,16'h0030,16'h0000);
      step(0, 1,0,16'h0030,16'h0000, 1,0,16'h0040,16'h0000, 0,16'h2222,  0,0,0,16'h2222,16'h0000, 1,0,16'h0030,16'h0000);
      step(0, 1,0,16'h0030,16'h0000, 1,0,16'h0040,16'h0000, 0,16'h3333,  1,1,0,16'h3333,16'h0000, 1,0,16'h0040,16'h0000);
      step(0, 1,0,16'h0030,16'h0000, 1,0,16'h0040,16'h0000, 0,16'h4444,  0,0,1,16'h0000,16'h4444, 1,0,16'h0030,16'h0000);
      step(0, 1,0,16'h0030,16'h0000, 1,0,16'h0040,16'h0000, 0,16'h5555,  0,0,0,16'h5555,16'h0000, 1,0,16'h0030,16'h0000);
      step(0, 1,0,16'h0030,16'h0000, 1,0,16'h0040,16'h0000, 0,16'h6666,  0,0,0,16'h6666,16'h0000, 1,0,16'h0030,16'h0000);
      step(0, 1,0,16'h0030,16'h0000, 1,0,16'h0040,16'h0000, 0,16'h7777,  1,1,0,16'h7777,16'h0000, 1,0,16'h0040,16'h0000);
      step(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,16'h8888,  0,0,1,16'h0000,16'h8888, 0,0,16'h0000,16'h0000);
      // 4: alternating CPU / EXT reads
      step(0, 1,0,16'h0050,16'h0000, 0,0,16'h0000,16'h0000, 0,16'h0000,  0,0,0,16'h0000,16'h0000, 1,0,16'h0050,16'h0000);
      step(0, 0,0,16'h0000,16'h0000, 1,0,16'h0060,16'h0000, 0,16'hAAAA,  0,1,0,16'hAAAA,16'h0000, 1,0,16'h0060,16'h0000);
      step(0, 1,0,16'h0052,16'h0000, 0,0,16'h0000,16'h0000, 0,16'hBBBB,  0,0,1,16'h0000,16'hBBBB, 1,0,16'h0052,16'h0000);
      step(0, 0,0,16'h0000,16'h0000, 1,0,16'h0062,16'h0000, 0,16'hCCCC,  0,1,0,16'hCCCC,16'h0000, 1,0,16'h0062,16'h0000);
      step(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,16'hDDDD,  0,0,1,16'h0000,16'hDDDD, 0,0,16'h0000,16'h0000);
      step(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,16'hEEEE,  0,0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000);
      // Reset mid-conflict: starvation count restarts, CPU keeps priority for 3 more cycles
      step(0, 1,1,16'h0070,16'h7070, 1,1,16'h0080,16'h8080, 0,16'h0000,  0,0,0,16'h0000,16'h0000, 1,1,16'h0070,16'h7070);
      step(0, 1,1,16'h0070,16'h7070, 1,1,16'h0080,16'h8080, 0,16'h0000,  0,0,0,16'h0000,16'h0000, 1,1,16'h0070,16'h7070);
      step(1, 1,1,16'h0070,16'h7070, 1,1,16'h0080,16'h8080, 0,16'h0000,  0,0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000);
      step(0, 1,1,16'h0070,16'h7070, 1,1,16'h0080,16'h8080, 0,16'h0000,  0,0,0,16'h0000,16'h0000, 1,1,16'h0070,16'h7070);
      step(0, 1,1,16'h0070,16'h7070, 1,1,16'h0080,16'h8080, 0,16'h0000,  0,0,0,16'h0000,16'h0000, 1,1,16'h0070,16'h7070);
      step(0, 1,1,16'h0070,16'h7070, 1,1,16'h0080,16'h8080, 0,16'h0000,  0,0,0,16'h0000,16'h0000, 1,1,16'h0070,16'h7070);
      step(0, 1,1,16'h0070,16'h7070, 1,1,16'h0080,16'h8080, 0,16'h0000,  1,1,0,16'h0000,16'h0000, 1,1,16'h0080,16'h8080);
      // 5: granted EXT read, then reset: response suppressed
      step(0, 0,0,16'h0000,16'h0000, 1,0,16'h0090,16'h0000, 0,16'h0000,  0,1,0,16'h0000,16'h0000, 1,0,16'h0090,16'h0000);
      step(1, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,16'hFFFF,  0,0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000);
      step(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,16'hFFFF,  0,0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000);
`ifdef DMEM_ARB_LOCK_EN
      // 6: locked EXT ownership for 5 CPU-conflict cycles, CPU wins once lock drops
      step(0, 0,0,16'h0000,16'h0000, 1,0,16'h00B0,16'h0000, 1,16'h0000,  0,1,0,16'h0000,16'h0000, 1,0,16'h00B0,16'h0000);
      for (int i = 0; i < 5; i++) begin
         step(0, 1,0,16'h00A0,16'h0000, 1,0,16'h00B0,16'h0000, 1,16'(i + 1),
              1,1,1,16'h0000,16'(i + 1), 1,0,16'h00B0,16'h0000);
      end
      step(0, 1,0,16'h00A0,16'h0000, 1,0,16'h00B0,16'h0000, 0,16'h0006,  0,0,1,16'h0000,16'h0006, 1,0,16'h00A0,16'h0000);
      step(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,16'h0007,  0,0,0,16'h0007,16'h0000, 0,0,16'h0000,16'h0000);
`endif

      // Drain: every queued expectation must be consumed within a few cycles.
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      if (n_cmp != vec_id) begin
         n_err++;
         $display("FAIL count: compared %0d vectors, want %0d", n_cmp, vec_id);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
